// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter that shares one data-memory port between NUM_REQ LSU lanes.
// Each grant runs one valid/ready memory handshake, then pulses resp_valid to the owner.
module lsu_mem_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lw_or_sw,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        mem_valid,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]     owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                lw_q, lw_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                found;
    logic [PtrW-1:0]     winner;
    logic [PtrW-1:0]     cand;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_lw;

    // First requesting lane at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PtrW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_lw    = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (winner == PtrW'(j)) begin
                sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[j*DATA_W +: DATA_W];
                sel_lw    = req_lw_or_sw[j];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lw_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lw_q     <= lw_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lw_d     = lw_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d = winner;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    lw_d    = sel_lw;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (mem_ready) begin
                    rdata_d = lw_q ? mem_rdata : '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                rr_ptr_d = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + PtrW'(1);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i]  = (state_q == StIdle) && found && (winner == PtrW'(i));
            resp_valid[i] = (state_q == StDone) && (owner_q == PtrW'(i));
        end
        if (state_q == StIssue) begin
            mem_valid = 1'b1;
            mem_we    = ~lw_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        busy = (state_q != StIdle);
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: table of single-lane transactions plus
// hand-written round-robin, wrap, mid-transaction reset and dropped-request sequences.
module tb_lsu_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_lw_or_sw;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              mem_valid;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata;
    logic              busy;

    lsu_mem_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_lw_or_sw (req_lw_or_sw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        bit          lw;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          k;
        logic [15:0] rdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input bit lw, input logic [15:0] addr,
                            input logic [15:0] wdata);
        req_lw_or_sw[lane]       = lw;
        req_addr[lane*AW +: AW]  = addr;
        req_wdata[lane*DW +: DW] = wdata;
    endtask

    // Single-lane transaction; entered and left at posedge+1 in IDLE.
    task automatic do_txn(input vec_t v, input string tag);
        logic [NR-1:0] oh;
        oh = NR'(1) << v.lane;
        set_lane(v.lane, v.lw, v.addr, v.wdata);
        req_valid = oh;
        #1;
        check({tag, " grant"}, 32'(req_ready), 32'(oh));
        check({tag, " idle busy"}, 32'(busy), 0);
        check({tag, " idle mem_valid"}, 32'(mem_valid), 0);
        step();
        req_valid = '0;
        for (int j = 0; j <= v.k; j++) begin
            mem_ready = (j == v.k);
            mem_rdata = (j == v.k) ? v.rdata : 16'hA5A5;
            #1;
            check({tag, " mem_valid"}, 32'(mem_valid), 1);
            check({tag, " mem_we"}, 32'(mem_we), 32'(!v.lw));
            check({tag, " mem_addr"}, 32'(mem_addr), 32'(v.addr));
            check({tag, " mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
            check({tag, " no early resp"}, 32'(resp_valid), 0);
            step();
        end
        mem_ready = 1'b0;
        mem_rdata = 16'h5A5A;
        #1;
        check({tag, " resp_valid"}, 32'(resp_valid), 32'(oh));
        check({tag, " resp_rdata"}, 32'(resp_rdata), 32'(v.exp_rdata));
        check({tag, " done mem_valid"}, 32'(mem_valid), 0);
        check({tag, " done busy"}, 32'(busy), 1);
        step();
        check({tag, " resp pulse ends"}, 32'(resp_valid), 0);
        check({tag, " rdata held"}, 32'(resp_rdata), 32'(v.exp_rdata));
        check({tag, " busy low"}, 32'(busy), 0);
    endtask

    initial begin
        int order[5];
        int ngr;
        int last;
        vec_t v;

        vecs[0] = '{lane: 2, lw: 1'b1, addr: 16'h0040, wdata: 16'h0000, k: 0,
                    rdata: 16'hBEEF, exp_rdata: 16'hBEEF};
        vecs[1] = '{lane: 1, lw: 1'b0, addr: 16'h0010, wdata: 16'h1234, k: 3,
                    rdata: 16'hDEAD, exp_rdata: 16'h0000};
        vecs[2] = '{lane: 0, lw: 1'b1, addr: 16'hFFFF, wdata: 16'h5555, k: 1,
                    rdata: 16'h0001, exp_rdata: 16'h0001};
        vecs[3] = '{lane: 3, lw: 1'b0, addr: 16'h8000, wdata: 16'hFFFF, k: 0,
                    rdata: 16'h7777, exp_rdata: 16'h0000};
        order = '{0, 1, 2, 3, 0};

        reset        = 1'b0;
        req_valid    = '0;
        req_lw_or_sw = '0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_ready    = 1'b0;
        mem_rdata    = '0;
        #2;
        check("rst req_ready", 32'(req_ready), 0);
        check("rst resp_valid", 32'(resp_valid), 0);
        check("rst resp_rdata", 32'(resp_rdata), 0);
        check("rst mem_valid", 32'(mem_valid), 0);
        check("rst mem_we", 32'(mem_we), 0);
        check("rst mem_addr", 32'(mem_addr), 0);
        check("rst mem_wdata", 32'(mem_wdata), 0);
        check("rst busy", 32'(busy), 0);
        #5 reset = 1'b1;
        step();

        for (int i = 0; i < 4; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // mem_ready while idle must not start anything.
        mem_ready = 1'b1;
        mem_rdata = 16'h9999;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("idle mem_ready busy", 32'(busy), 0);
            check("idle mem_ready resp", 32'(resp_valid), 0);
            check("idle mem_ready rdata", 32'(resp_rdata), 0);
            step();
        end

        // All lanes requesting, memory always ready; rr_ptr is 0 after lane 3.
        for (int l = 0; l < NR; l++) set_lane(l, 1'b1, 16'(l * 256), 16'h0);
        req_valid = '1;
        ngr  = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && ngr < 5; cyc++) begin
            #1;
            if (req_ready != '0) begin
                check($sformatf("rr grant %0d", ngr), 32'(req_ready), 32'(1) << order[ngr]);
                if (ngr > 0) check($sformatf("rr spacing %0d", ngr), 32'(cyc - last), 3);
                last = cyc;
                ngr++;
            end
            step();
        end
        check("rr grant count", 32'(ngr), 5);
        req_valid = '0;
        step();
        step();
        mem_ready = 1'b0;

        // Lane 3 alone, then lanes 0 and 3 together: pointer has wrapped to 0.
        v = '{lane: 3, lw: 1'b1, addr: 16'h0333, wdata: 16'h0, k: 0,
              rdata: 16'h3333, exp_rdata: 16'h3333};
        do_txn(v, "lane3");
        set_lane(0, 1'b1, 16'h0100, 16'h0);
        req_valid = 4'b1001;
        #1;
        check("wrap grant lane0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b1000;
        mem_ready = 1'b1;
        step();
        #1;
        check("wrap resp lane0", 32'(resp_valid), 32'h1);
        step();
        check("wrap then lane3", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        step();
        step();
        mem_ready = 1'b0;

        // Leave rr_ptr at 3, then reset while lane 1 is in flight.
        v = '{lane: 2, lw: 1'b0, addr: 16'h0222, wdata: 16'h2222, k: 0,
              rdata: 16'h0, exp_rdata: 16'h0};
        do_txn(v, "lane2");
        set_lane(1, 1'b1, 16'h0111, 16'h0);
        req_valid = 4'b0010;
        #1;
        check("pre-rst grant lane1", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        #1;
        check("pre-rst mem_valid", 32'(mem_valid), 1);
        reset = 1'b0;
        #1;
        check("async rst mem_valid", 32'(mem_valid), 0);
        check("async rst busy", 32'(busy), 0);
        check("async rst mem_addr", 32'(mem_addr), 0);
        mem_ready = 1'b1;
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no resp after rst", 32'(resp_valid), 0);
        end
        mem_ready = 1'b0;
        set_lane(3, 1'b1, 16'h0333, 16'h0);
        req_valid = 4'b1001;
        #1;
        check("post-rst search from 0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;

        // Lane 0 raises then drops its request while lane 2 owns the bus.
        set_lane(2, 1'b1, 16'h0242, 16'h0);
        req_valid = 4'b0100;
        #1;
        check("drop grant lane2", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0001;
        #1;
        check("drop no grant in issue", 32'(req_ready), 0);
        check("drop busy issue", 32'(busy), 1);
        step();
        req_valid = '0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        check("drop resp lane2", 32'(resp_valid), 32'h4);
        check("drop busy done", 32'(busy), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("drop lane0 skipped", 32'(req_ready), 0);
            check("drop busy low", 32'(busy), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
